// File: rtl/divider.sv
// Multi-cycle radix-2 restoring divider for the execute stage (DIV/DIVU/REM/REMU).
// Quotient and remainder arrive together with a one-cycle done pulse; flush aborts silently.
module divider #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid,
    input  logic             is_signed,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             neg_q, neg_r;

    logic             accept, div0, ovf;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] rem_step, q_step;

    assign accept = (state == IDLE) && valid && !flush;
    assign div0   = (b == '0);
    assign ovf    = is_signed && (a == MIN_NEG) && (b == '1);
    assign abs_a  = (is_signed && a[WIDTH-1]) ? -a : a;
    assign abs_b  = (is_signed && b[WIDTH-1]) ? -b : b;

    // Quotient bits shift into the dividend register as its bits are consumed.
    assign shifted  = {rem, dvd[WIDTH-1]};
    assign diff     = shifted - {1'b0, dvs};
    assign rem_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_step   = {dvd[WIDTH-2:0], ~diff[WIDTH]};

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (div0 || ovf) ? DONE : BUSY;
            BUSY: begin
                if (flush)                 state_next = IDLE;
                else if (cnt == CW'(1))    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt   <= '0;
            rem   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            q     <= '0;
            r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (div0) begin
                            q <= '1;
                            r <= a;
                        end else if (ovf) begin
                            q <= a;
                            r <= '0;
                        end else begin
                            dvd   <= abs_a;
                            dvs   <= abs_b;
                            rem   <= '0;
                            cnt   <= CW'(WIDTH);
                            neg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r <= is_signed && a[WIDTH-1];
                        end
                    end
                end
                BUSY: begin
                    if (!flush) begin
                        rem <= rem_step;
                        dvd <= q_step;
                        cnt <= cnt - CW'(1);
                        // Final iteration publishes the sign-corrected result.
                        if (cnt == CW'(1)) begin
                            q <= neg_q ? -q_step : q_step;
                            r <= neg_r ? -rem_step : rem_step;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/divider.md
Name: divider

Overview:
Multi-cycle radix-2 restoring integer divider for the execute stage. It implements the RV64 M-extension DIV/DIVU/REM/REMU semantics, producing quotient and remainder together. It is the inverse-operation companion of the execute-stage sequential multiplier and uses the same valid/done handshake style. The execute stage issues a request with valid and stalls until done pulses.

Parameters:
WIDTH, 64, operand, quotient and remainder width in bits.

Ports:
clk  input  1  clock
resetn  input  1  reset, synchronous, active-low
valid  input  1  request; sampled only in IDLE
is_signed  input  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU
flush  input  1  synchronous abort of an in-flight operation (pipeline flush)
a  input  WIDTH  dividend; sampled on the accepting edge only
b  input  WIDTH  divisor; sampled on the accepting edge only
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; q and r are valid in this cycle
q  output  WIDTH  quotient
r  output  WIDTH  remainder

Behaviour:
- Reset: state=IDLE; busy=0, done=0, q=0, r=0; all internal registers 0. Reset has priority over every other input, including mid-operation. An aborted operation never produces done.
- States: IDLE, BUSY, DONE. busy=1 in BUSY and DONE. done=1 only in DONE.
- Accept: in IDLE, valid=1 and flush=0 at edge E0 -> latch a, b, is_signed.
  - Special case (b==0): go directly to DONE with q=all ones, r=a, for both signed and unsigned.
  - Special case (is_signed, a==2^(WIDTH-1), b==all ones): go directly to DONE with q=a, r=0.
  - Otherwise: go to BUSY with iteration counter=WIDTH.
  - Special-case latency: done is high in the cycle immediately after E0.
- Signed preprocessing at accept: operate on |a| and |b|. Record neg_q = sign(a) XOR sign(b) and neg_r = sign(a).
- BUSY, one iteration per edge:
  - Shift the (WIDTH+1)-bit partial remainder left, bringing in the next dividend MSB.
  - Trial-subtract |b|. If the result is non-negative, keep it and shift quotient bit 1; else restore and shift 0.
  - Decrement the counter.
  - On the edge that performs iteration WIDTH (edge E0+WIDTH), write q and r with sign correction applied (negate q if neg_q, negate r if neg_r) and go to DONE.
  - Normal latency: done is high in the cycle after edge E0+WIDTH.
- DONE: lasts exactly one cycle, then returns to IDLE. valid is ignored in DONE. The earliest next accept is the edge that leaves DONE+1, i.e. valid must be high in IDLE.
- q and r hold their values from completion until the next completion or reset. They are not cleared by flush or by a new accept.
- valid in BUSY or DONE: ignored, not queued. The requester must hold valid and operands until done.
- flush=1 in BUSY: next state IDLE, no done, q/r unchanged. flush=1 in DONE: done still pulses this cycle, then IDLE. flush=1 in IDLE: suppresses accept even if valid=1.
- Unsigned mode treats all bits as magnitude. No special case applies other than b==0.
- Invariant on completion: a == q*b + r (mod 2^WIDTH). |r| < |b|, and r has the sign of a or is zero.

Test Plan:
1. Unsigned 100/7 (is_signed=0) -> done exactly in the cycle after E0+64; q=14, r=2; busy high E0+1..E0+65 cycles, low afterwards.
2. Signed -7/2 -> q=0xFFFF_FFFF_FFFF_FFFD (-3), r=0xFFFF_FFFF_FFFF_FFFF (-1). Signed 7/-2 -> q=-3, r=1.
3. Divide by zero: a=5, b=0 (signed and unsigned) -> done in the cycle after E0; q=0xFFFF_FFFF_FFFF_FFFF, r=5.
4. Signed overflow: a=0x8000_0000_0000_0000, b=all ones -> done after 1 cycle; q=0x8000_0000_0000_0000, r=0. The same operands unsigned -> normal 64-cycle path; q=0, r=0x8000_0000_0000_0000.
5. flush at 10 cycles into BUSY -> no done, busy=0 next cycle, q/r retain the prior result. An immediate follow-up 1000/10 -> q=100, r=0. valid toggled during BUSY has no effect.
6. resetn low at cycle 30 of an operation -> q=r=0, done never asserted; after release, 0xFFFF_FFFF_FFFF_FFFF/3 unsigned -> q=0x5555_5555_5555_5555, r=0. Back-to-back ops: the second accept occurs in the cycle following DONE.
